// File: rtl/period_select.sv
// Push-button front end for the heartbeat LED pattern generator.
// Synchronises and debounces the raw button, then turns presses into the
// 2-bit period code: a short press steps 0->1->2->3->0 and a long press
// clears it to 0.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   io_btn     raw push-button, active-low, asynchronous to clock
//   io_period  current period code (registered)
//   io_pressed debounced button level, 1 = pressed (registered)
//   io_step    one-cycle pulse when a short press increments io_period
//   io_clear   one-cycle pulse when a long press clears io_period
module period_select #(
    parameter int unsigned DB_CYCLES   = 240000,
    parameter int unsigned LONG_CYCLES = 12000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_btn,
    output logic [1:0] io_period,
    output logic       io_pressed,
    output logic       io_step,
    output logic       io_clear
);

    localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic              sync1_q;
    logic              sync2_q;
    logic              db_level_q;
    logic              db_level_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic              pressed_q;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic [1:0]        period_q;
    logic [1:0]        period_d;
    logic              step_q;
    logic              step_d;
    logic              clear_q;
    logic              clear_d;
    logic              press_edge_c;

    // Two-flop synchroniser; db_level is the debounced raw level (1 = released).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= io_btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive differing samples.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Press edge is taken from the next debounced level so HELD starts on the
    // same edge that raises io_pressed.
    assign press_edge_c = db_level_q & ~db_level_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            pressed_q  <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            pressed_q  <= ~db_level_d;
        end
    end

    // Press classifier: threshold check wins over a coincident release.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        period_d = period_q;
        step_d   = 1'b0;
        clear_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_edge_c) begin
                    hold_d  = '0;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (hold_q == HOLD_LAST) begin
                    period_d = 2'd0;
                    clear_d  = 1'b1;
                    hold_d   = '0;
                    state_d  = ST_LONG;
                end else if (db_level_q) begin
                    period_d = period_q + 2'd1;
                    step_d   = 1'b1;
                    hold_d   = '0;
                    state_d  = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (db_level_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                hold_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            period_q <= 2'd0;
            step_q   <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            period_q <= period_d;
            step_q   <= step_d;
            clear_q  <= clear_d;
        end
    end

    assign io_period  = period_q;
    assign io_pressed = pressed_q;
    assign io_step    = step_q;
    assign io_clear   = clear_q;

endmodule

// File: doc/period_select.md
Name: period_select

Overview:
- Upstream control stage for the heartbeat LED pattern generator.
- Debounces the board push-button and converts presses into the 2-bit period code that drives the generator's period input (`io_period`).
- A short press steps the period 0→1→2→3→0; a long press clears it to 0.
- Runs on the board system clock, not the slow pattern clock.

Parameters:
- DB_CYCLES, 240000, consecutive stable samples needed to accept a button level change (20 ms at 12 MHz)
- LONG_CYCLES, 12000000, hold duration in cycles that makes a press "long" (1 s at 12 MHz)

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- io_btn  input  1  raw push-button, active-low (0 = pressed), asynchronous to clock
- io_period  output  2  current period code, registered
- io_pressed  output  1  debounced button level, 1 = pressed
- io_step  output  1  one-cycle pulse when a short press increments io_period
- io_clear  output  1  one-cycle pulse when a long press clears io_period

Behaviour:
- Reset (reset = 0, asynchronous, no clock needed):
  - Both sync flops = 1 and the debounced level = released.
  - Debounce counter = 0, hold counter = 0, FSM = IDLE.
  - io_period = 0, io_pressed = 0, io_step = 0, io_clear = 0.
- Synchroniser: two flops on io_btn; the second flop's output is btn_s. Nothing else samples io_btn.
- Debounce:
  - If btn_s equals the debounced level, the counter resets to 0.
  - Otherwise the counter increments. When it would reach DB_CYCLES, the debounced level takes btn_s and the counter returns to 0.
  - A level change needs DB_CYCLES consecutive differing samples; any equal sample restarts the count.
  - io_pressed is the inverted debounced level, registered.
  - Latency from a clean io_btn edge to io_pressed change = 2 + DB_CYCLES cycles.
- FSM states: IDLE, HELD, LONG.
  - IDLE: on a debounced press edge (io_pressed 0→1), clear the hold counter and go to HELD.
  - HELD, each cycle, evaluated in this order:
    - (a) If hold counter == LONG_CYCLES-1: io_period ← 0, io_clear = 1 for one cycle, go to LONG.
    - (b) Else if the debounced level is released: io_period ← io_period + 1 modulo 4 (3 wraps to 0), io_step = 1 for one cycle, go to IDLE.
    - (c) Else increment the hold counter.
    - Long detection has priority when release and threshold coincide.
  - LONG: wait for debounced release, then go to IDLE. No step, no second clear.
- io_step and io_clear are registered and never both high. Each is high for exactly one cycle per event. io_period changes on the same edge that raises the pulse.
- Hold counter width: ceil(log2(LONG_CYCLES)). Debounce counter width: ceil(log2(DB_CYCLES)). Neither counter wraps: the debounce counter is cleared at DB_CYCLES, the hold counter on leaving HELD.
- Reset asserted mid-press: immediate return to reset values, period lost.
  - If the button is still held after reset deasserts, the debounced level starts as released.
  - That held button is therefore accepted as a new press after 2 + DB_CYCLES cycles.
- Glitches shorter than DB_CYCLES cycles (after synchronisation) produce no io_pressed change and no pulses.

Test Plan:
Use DB_CYCLES = 4, LONG_CYCLES = 20, 10 ns clock.
- Reset: hold reset = 0 with io_btn toggling → io_period = 0, io_pressed = 0, io_step = io_clear = 0 throughout. Release reset, io_btn = 1 → outputs stay 0.
- Bounce rejection: drive io_btn low for 2 cycles, high 2, low 3, high → io_pressed never rises, no pulses, io_period = 0.
- Short press sequence with wrap: four presses, each held 8 cycles low and separated by 10 cycles high.
  - io_period goes 1, 2, 3, 0, with exactly four io_step pulses.
  - io_pressed rises 6 cycles after each falling edge of io_btn.
- Long press: from io_period = 2, hold io_btn low for 40 cycles.
  - io_clear pulses once, 20 cycles after io_pressed rises; io_period becomes 0.
  - Release gives no io_step; io_period stays 0.
- Coincidence: time the release so the debounced release lands exactly on hold count 19 → io_clear pulses, io_step does not, io_period = 0.
- Mid-press reset: assert reset 5 cycles into HELD with io_period = 1.
  - io_period = 0 immediately, no pulse.
  - Keep io_btn low after deassert → io_pressed rises 6 cycles later.
  - Release after 8 cycles → io_step pulses, io_period = 1.
